// File: rtl/ped_signal_sequencer.sv
// rtl/ped_signal_sequencer.sv - 1 Hz timing and position sequencer for the pedestrian LED driver
//
// Purpose:
//   Divides CLK down to a one-cycle 1 Hz tick and a 50% duty 1 Hz blink.
//   Walks crosswalk positions 0..3 in turn. Each position counts down its
//   walk time, then waits through an all-off gap. Night mode forces all
//   lights out. Hold freezes the countdown. Inputs are acted on only in
//   the tick cycle.
//
// Ports:
//   CLK              in   system clock
//   RST              in   synchronous reset, active-high
//   Night_mode       in   lights-out request (level, sampled on ticks)
//   Hold             in   countdown freeze (level, sampled on ticks)
//   Ped_signal_time  out  remaining walk seconds, 0 in gap / lights-out
//   Signal_pos       out  active crosswalk position
//   Light_out_time   out  1 = all pedestrian LEDs off
//   Blink_1Hz        out  1 Hz square wave, high for the first half second
//   Tick_1Hz         out  one-CLK pulse per second

module ped_signal_sequencer #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int PED_TIME    = 20,
    parameter int GAP_TIME    = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Night_mode,
    input  logic       Hold,
    output logic [4:0] Ped_signal_time,
    output logic [1:0] Signal_pos,
    output logic       Light_out_time,
    output logic       Blink_1Hz,
    output logic       Tick_1Hz
);

    if (CLK_FREQ_HZ < 2) begin : g_bad_clk_freq
        $error("ped_signal_sequencer: CLK_FREQ_HZ must be >= 2");
    end
    if (PED_TIME < 1 || PED_TIME > 31) begin : g_bad_ped_time
        $error("ped_signal_sequencer: PED_TIME must be in 1..31");
    end
    if (GAP_TIME < 0 || GAP_TIME > 15) begin : g_bad_gap_time
        $error("ped_signal_sequencer: GAP_TIME must be in 0..15");
    end

    localparam int CNT_W = (CLK_FREQ_HZ > 2) ? $clog2(CLK_FREQ_HZ) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_FREQ_HZ - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_FREQ_HZ / 2);
    localparam logic [4:0]       PED_T    = 5'(PED_TIME);
    localparam logic [3:0]       GAP_T    = 4'(GAP_TIME);

    typedef enum logic [1:0] {
        ST_WALK = 2'd0,
        ST_GAP  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] presc_cnt;
    logic [CNT_W-1:0] presc_next;
    logic [3:0]       gap_cnt;

    always_comb begin
        presc_next = presc_cnt + 1'b1;
        if (presc_cnt == CNT_MAX) begin
            presc_next = '0;
        end
    end

    // Free-running prescaler. Blink is registered from the next count so it
    // stays aligned with presc_cnt (high while count < CLK_FREQ_HZ/2).
    always_ff @(posedge CLK) begin
        if (RST) begin
            presc_cnt <= '0;
            Tick_1Hz  <= 1'b0;
            Blink_1Hz <= 1'b1;
        end else begin
            presc_cnt <= presc_next;
            Tick_1Hz  <= (presc_cnt == CNT_MAX);
            Blink_1Hz <= (presc_next < CNT_HALF);
        end
    end

    // Sequencer: everything advances only in the tick cycle, so its effect
    // shows one cycle after Tick_1Hz.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state           <= ST_WALK;
            Signal_pos      <= 2'd0;
            Ped_signal_time <= PED_T;
            Light_out_time  <= 1'b0;
            gap_cnt         <= 4'd0;
        end else if (Tick_1Hz) begin
            case (state)
                ST_WALK: begin
                    if (Night_mode) begin
                        state           <= ST_OUT;
                        Light_out_time  <= 1'b1;
                        Ped_signal_time <= 5'd0;
                    end else if (!Hold) begin
                        if (Ped_signal_time > 5'd1) begin
                            Ped_signal_time <= Ped_signal_time - 5'd1;
                        end else if (GAP_TIME > 0) begin
                            state           <= ST_GAP;
                            Ped_signal_time <= 5'd0;
                            gap_cnt         <= GAP_T;
                        end else begin
                            Signal_pos      <= Signal_pos + 2'd1;
                            Ped_signal_time <= PED_T;
                        end
                    end
                end
                ST_GAP: begin
                    if (Night_mode) begin
                        state           <= ST_OUT;
                        Light_out_time  <= 1'b1;
                        Ped_signal_time <= 5'd0;
                        gap_cnt         <= 4'd0;
                    end else if (!Hold) begin
                        if (gap_cnt <= 4'd1) begin
                            gap_cnt         <= 4'd0;
                            state           <= ST_WALK;
                            Signal_pos      <= Signal_pos + 2'd1;
                            Ped_signal_time <= PED_T;
                        end else begin
                            gap_cnt <= gap_cnt - 4'd1;
                        end
                    end
                end
                ST_OUT: begin
                    // Hold has no meaning with the lights out; only Night_mode
                    // release matters, and it restarts from position 0.
                    if (!Night_mode) begin
                        state           <= ST_WALK;
                        Signal_pos      <= 2'd0;
                        Ped_signal_time <= PED_T;
                        Light_out_time  <= 1'b0;
                    end
                end
                default: begin
                    state           <= ST_WALK;
                    Signal_pos      <= 2'd0;
                    Ped_signal_time <= PED_T;
                    Light_out_time  <= 1'b0;
                    gap_cnt         <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ped_signal_sequencer.sv
// tb/tb_ped_signal_sequencer.sv - directed scoreboard bench for ped_signal_sequencer

module tb_ped_signal_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Night_mode = 1'b0;
    logic       Hold = 1'b0;
    logic [4:0] Ped_signal_time;
    logic [1:0] Signal_pos;
    logic       Light_out_time;
    logic       Blink_1Hz;
    logic       Tick_1Hz;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0] t;
        logic [1:0] pos;
        logic       lo;
    } exp_t;

    exp_t exp_q[$];

    ped_signal_sequencer #(
        .CLK_FREQ_HZ(4),
        .PED_TIME   (3),
        .GAP_TIME   (2)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .Night_mode     (Night_mode),
        .Hold           (Hold),
        .Ped_signal_time(Ped_signal_time),
        .Signal_pos     (Signal_pos),
        .Light_out_time (Light_out_time),
        .Blink_1Hz      (Blink_1Hz),
        .Tick_1Hz       (Tick_1Hz)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    // Drive inputs, push the expected post-tick outputs, wait for the tick,
    // then pop and compare one cycle later.
    task automatic step(input string tag, input logic night, input logic hold,
                        input logic [4:0] t, input logic [1:0] pos, input logic lo);
        exp_t e;
        bit   got;
        Night_mode = night;
        Hold       = hold;
        e.t = t; e.pos = pos; e.lo = lo;
        exp_q.push_back(e);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            if (Tick_1Hz === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, "_tick_seen"}, 32'(got), 32'd1);
        @(negedge CLK);
        e = exp_q.pop_front();
        chk({tag, "_time"}, 32'(Ped_signal_time), 32'(e.t));
        chk({tag, "_pos"},  32'(Signal_pos),      32'(e.pos));
        chk({tag, "_lout"}, 32'(Light_out_time),  32'(e.lo));
        chk({tag, "_tick_width"}, 32'(Tick_1Hz),  32'd0);
    endtask

    // Five ticks across one position: countdown, two gap seconds, advance.
    task automatic run_position(input string tag, input logic [1:0] pos);
        step(tag, 0, 0, 5'd2, pos, 0);
        step(tag, 0, 0, 5'd1, pos, 0);
        step(tag, 0, 0, 5'd0, pos, 0);
        step(tag, 0, 0, 5'd0, pos, 0);
        step(tag, 0, 0, 5'd3, pos + 2'd1, 0);
    endtask

    initial begin
        logic [3:0] blink_pat;
        int         wait_n;
        blink_pat = 4'b0011;

        // Reset state
        do_reset();
        chk("rst_time", 32'(Ped_signal_time), 32'd3);
        chk("rst_pos",  32'(Signal_pos),      32'd0);
        chk("rst_lout", 32'(Light_out_time),  32'd0);
        chk("rst_tick", 32'(Tick_1Hz),        32'd0);

        // T1: one prescaler period, blink 1,1,0,0, no tick yet
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_blink%0d", i), 32'(Blink_1Hz), 32'(blink_pat[i]));
            chk($sformatf("t1_tick%0d", i),  32'(Tick_1Hz),  32'd0);
            if (i < 3) @(negedge CLK);
        end

        // T2: position 0 -> 1
        run_position("t2_p0", 2'd0);

        // T3: hold at time=2 for three ticks, then resume
        step("t3_a",    0, 0, 5'd2, 2'd1, 0);
        step("t3_h1",   0, 1, 5'd2, 2'd1, 0);
        step("t3_h2",   0, 1, 5'd2, 2'd1, 0);
        step("t3_h3",   0, 1, 5'd2, 2'd1, 0);
        step("t3_res",  0, 0, 5'd1, 2'd1, 0);
        step("t3_gap1", 0, 0, 5'd0, 2'd1, 0);
        step("t3_gap2", 0, 0, 5'd0, 2'd1, 0);
        step("t3_adv",  0, 0, 5'd3, 2'd2, 0);

        // T4: night mode during GAP at position 2
        step("t4_w2",   0, 0, 5'd2, 2'd2, 0);
        step("t4_w1",   0, 0, 5'd1, 2'd2, 0);
        step("t4_gap",  0, 0, 5'd0, 2'd2, 0);
        step("t4_out",  1, 0, 5'd0, 2'd2, 1);
        step("t4_out2", 1, 0, 5'd0, 2'd2, 1);
        step("t4_rel",  0, 0, 5'd3, 2'd0, 0);

        // T5: night and hold together; then hold alone is ignored in OUT
        step("t5_both", 1, 1, 5'd0, 2'd0, 1);
        step("t5_rel",  0, 1, 5'd3, 2'd0, 0);

        // Night pulse between ticks has no effect
        @(negedge CLK);
        Night_mode = 1'b1;
        @(negedge CLK);
        Night_mode = 1'b0;
        step("nt_pulse", 0, 0, 5'd2, 2'd0, 0);
        step("nt_b",     0, 0, 5'd1, 2'd0, 0);
        step("nt_c",     0, 0, 5'd0, 2'd0, 0);
        step("nt_d",     0, 0, 5'd0, 2'd0, 0);
        step("nt_e",     0, 0, 5'd3, 2'd1, 0);

        // T2 continued: walk to position 3 and wrap to 0
        run_position("t2_p1", 2'd1);
        run_position("t2_p2", 2'd2);
        run_position("t2_p3", 2'd3);
        chk("t2_wrap_pos", 32'(Signal_pos), 32'd0);

        // T6: reset mid-GAP at position 3
        run_position("t6_p0", 2'd0);
        run_position("t6_p1", 2'd1);
        run_position("t6_p2", 2'd2);
        step("t6_w2",  0, 0, 5'd2, 2'd3, 0);
        step("t6_w1",  0, 0, 5'd1, 2'd3, 0);
        step("t6_gap", 0, 0, 5'd0, 2'd3, 0);
        do_reset();
        chk("t6_time",  32'(Ped_signal_time), 32'd3);
        chk("t6_pos",   32'(Signal_pos),      32'd0);
        chk("t6_lout",  32'(Light_out_time),  32'd0);
        chk("t6_blink", 32'(Blink_1Hz),       32'd1);
        chk("t6_tick",  32'(Tick_1Hz),        32'd0);
        wait_n = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge CLK);
            if (Tick_1Hz === 1'b1) begin
                wait_n = i;
                break;
            end
        end
        chk("t6_presc_restart", 32'(wait_n), 32'd4);
        @(negedge CLK);
        chk("t6_first_tick_time", 32'(Ped_signal_time), 32'd2);
        chk("t6_first_tick_pos",  32'(Signal_pos),      32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
